// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller: phase codes,
// clock-rate encodings, default phase durations and the tick-rate helper.
package wm_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;

    localparam logic [1:0] CLK_1X = 2'b00;
    localparam logic [1:0] CLK_2X = 2'b01;
    localparam logic [1:0] CLK_4X = 2'b10;
    localparam logic [1:0] CLK_8X = 2'b11;

    localparam int unsigned BASE_TICKS_DEF = 32'd1_000_000;
    localparam int unsigned FILL_SEC_DEF   = 32'd120;
    localparam int unsigned WASH_SEC_DEF   = 32'd300;
    localparam int unsigned RINSE_SEC_DEF  = 32'd120;

    typedef enum logic [2:0] {
        ST_IDLE  = PH_IDLE,
        ST_FILL  = PH_FILL,
        ST_WASH  = PH_WASH,
        ST_RINSE = PH_RINSE,
        ST_SPIN  = PH_SPIN
    } state_e;

    // Clock cycles per second at the selected clock-rate multiplier.
    function automatic logic [31:0] ticks_per_sec(input logic [31:0] base,
                                                  input logic [1:0]  freq);
        logic [31:0] t;
        case (freq)
            CLK_1X:  t = base;
            CLK_2X:  t = base << 1;
            CLK_4X:  t = base << 2;
            CLK_8X:  t = base << 3;
            default: t = base;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Seconds timebase for the timed phases: a prescaler that wraps once per
// second and a seconds counter that flags the last tick of the phase.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned BASE_TICKS_PER_SEC = BASE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       freeze_i,
    input  logic [1:0] cfg_clk_freq_i,
    input  logic [8:0] dur_i,
    output logic       expire_o
);

    logic [31:0] pre_q, pre_d;
    logic [8:0]  sec_q, sec_d;
    logic [31:0] wrap_s;
    logic        sec_tick_s;

    // Second boundary detection and phase-expiry flag.
    always_comb begin
        wrap_s     = ticks_per_sec(32'(BASE_TICKS_PER_SEC), cfg_clk_freq_i) - 32'd1;
        sec_tick_s = !freeze_i && (pre_q == wrap_s);
        expire_o   = sec_tick_s && (sec_q == (dur_i - 9'd1));
    end

    // Counter next-state; clear wins over freeze so a state change always restarts the phase.
    always_comb begin
        pre_d = pre_q;
        sec_d = sec_q;
        if (clear_i) begin
            pre_d = 32'd0;
            sec_d = 9'd0;
        end else if (freeze_i) begin
            pre_d = pre_q;
            sec_d = sec_q;
        end else if (sec_tick_s) begin
            pre_d = 32'd0;
            sec_d = sec_q + 9'd1;
        end else begin
            pre_d = pre_q + 32'd1;
            sec_d = sec_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= 32'd0;
            sec_q <= 9'd0;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program sequencer IDLE->FILL->WASH->RINSE->SPIN->IDLE.
// Optional door interlock is compiled in with `define DOOR_LOCK_EN.
module wash_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned BASE_TICKS_PER_SEC = BASE_TICKS_DEF,
    parameter int unsigned FILL_SEC           = FILL_SEC_DEF,
    parameter int unsigned WASH_SEC           = WASH_SEC_DEF,
    parameter int unsigned RINSE_SEC          = RINSE_SEC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_in,
    input  logic       double_wash,
    input  logic       timer_pause,
    input  logic [1:0] clk_freq,
    input  logic       spining_done,
`ifdef DOOR_LOCK_EN
    input  logic       door_closed,
    output logic       door_lock,
`endif
    output logic [1:0] cfg_clk_freq,
    output logic       soft_rst,
    output logic       start_spining,
    output logic       spining_counter_stop,
    output logic       wash_done,
    output logic [2:0] phase
);

    state_e     state_q, state_d;
    logic       dbl_q, dbl_d;
    logic       pass_q, pass_d;
    logic [1:0] cfg_q, cfg_d;
    logic       wash_done_q, wash_done_d;
    logic [2:0] phase_q;
    logic       soft_rst_q, start_q, stop_q;
    logic       door_ok_s, freeze_s, clear_s, expire_s;
    logic [8:0] dur_s;

`ifdef DOOR_LOCK_EN
    logic door_lock_q;
    assign door_ok_s = door_closed;
    assign door_lock = door_lock_q;
`else
    assign door_ok_s = 1'b1;
`endif

    // An open door mid-cycle holds the timebase where it is.
    assign freeze_s = (state_q != ST_IDLE) && !door_ok_s;
    assign clear_s  = (state_q == ST_IDLE) || (state_d != state_q);

    // Duration of the currently running timed phase.
    always_comb begin
        case (state_q)
            ST_FILL:  dur_s = 9'(FILL_SEC);
            ST_WASH:  dur_s = 9'(WASH_SEC);
            ST_RINSE: dur_s = 9'(RINSE_SEC);
            default:  dur_s = 9'(FILL_SEC);
        endcase
    end

    wm_phase_timer #(
        .BASE_TICKS_PER_SEC(BASE_TICKS_PER_SEC)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_s),
        .freeze_i       (freeze_s),
        .cfg_clk_freq_i (cfg_q),
        .dur_i          (dur_s),
        .expire_o       (expire_s)
    );

    // Sequencer next-state and the settings captured at coin acceptance.
    always_comb begin
        state_d     = state_q;
        dbl_d       = dbl_q;
        pass_d      = pass_q;
        cfg_d       = cfg_q;
        wash_done_d = wash_done_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_in && door_ok_s) begin
                    cfg_d       = clk_freq;
                    dbl_d       = double_wash;
                    pass_d      = 1'b0;
                    wash_done_d = 1'b0;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (expire_s) begin
                    state_d = ST_WASH;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WASH: begin
                if (expire_s) begin
                    state_d = ST_RINSE;
                end else begin
                    state_d = ST_WASH;
                end
            end
            ST_RINSE: begin
                if (expire_s && dbl_q && !pass_q) begin
                    pass_d  = 1'b1;
                    state_d = ST_WASH;
                end else if (expire_s) begin
                    state_d = ST_SPIN;
                end else begin
                    state_d = ST_RINSE;
                end
            end
            ST_SPIN: begin
                if (spining_done && door_ok_s) begin
                    wash_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_SPIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and outputs decoded from the next state, valid in a state's first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dbl_q       <= 1'b0;
            pass_q      <= 1'b0;
            cfg_q       <= CLK_1X;
            wash_done_q <= 1'b0;
            phase_q     <= PH_IDLE;
            soft_rst_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
`ifdef DOOR_LOCK_EN
            door_lock_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dbl_q       <= dbl_d;
            pass_q      <= pass_d;
            cfg_q       <= cfg_d;
            wash_done_q <= wash_done_d;
            phase_q     <= state_d;
            soft_rst_q  <= (state_d != ST_IDLE);
            start_q     <= (state_d == ST_SPIN);
            stop_q      <= (state_d == ST_SPIN) && (timer_pause || !door_ok_s);
`ifdef DOOR_LOCK_EN
            door_lock_q <= (state_d != ST_IDLE);
`endif
        end
    end

    assign cfg_clk_freq         = cfg_q;
    assign soft_rst             = soft_rst_q;
    assign start_spining        = start_q;
    assign spining_counter_stop = stop_q;
    assign wash_done            = wash_done_q;
    assign phase                = phase_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl with randomized coins, clock rates,
// double-wash selection and pause/coin noise, plus a behavioural spin counter.
module tb_wash_cycle_ctrl;

    localparam int BASE       = 2;
    localparam int FS         = 3;
    localparam int WS         = 5;
    localparam int RS         = 3;
    localparam int SPIN_TICKS = 8;
    localparam int TMO        = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_in = 1'b0;
    logic       double_wash = 1'b0;
    logic       timer_pause = 1'b0;
    logic [1:0] clk_freq = 2'b00;
    logic       spining_done;
    logic [1:0] cfg_clk_freq;
    logic       soft_rst, start_spining, spining_counter_stop, wash_done;
    logic [2:0] phase;
`ifdef DOOR_LOCK_EN
    logic       door_closed = 1'b1;
    logic       door_lock;
`endif

    typedef struct {
        int       ph;
        int       prev_dur;
        int       prev_stops;
        int       cfg;
        int       wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   mon_resync = 1'b0;
    bit   started = 1'b0;
    bit   after_reset = 1'b1;
    int   spin_cnt = 0;
    int   m_prev = 0;
    int   m_dur = 0;
    int   m_stops = 0;

    always #5 clk = ~clk;

    wash_cycle_ctrl #(
        .BASE_TICKS_PER_SEC(BASE),
        .FILL_SEC(FS),
        .WASH_SEC(WS),
        .RINSE_SEC(RS)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .coin_in              (coin_in),
        .double_wash          (double_wash),
        .timer_pause          (timer_pause),
        .clk_freq             (clk_freq),
        .spining_done         (spining_done),
`ifdef DOOR_LOCK_EN
        .door_closed          (door_closed),
        .door_lock            (door_lock),
`endif
        .cfg_clk_freq         (cfg_clk_freq),
        .soft_rst             (soft_rst),
        .start_spining        (start_spining),
        .spining_counter_stop (spining_counter_stop),
        .wash_done            (wash_done),
        .phase                (phase)
    );

    // External spin counter: cleared while soft_rst is low, counts when enabled and not frozen.
    always @(posedge clk) begin
        if (!soft_rst)
            spin_cnt <= 0;
        else if (start_spining && !spining_counter_stop && spin_cnt < SPIN_TICKS)
            spin_cnt <= spin_cnt + 1;
    end
    assign spining_done = (spin_cnt == SPIN_TICKS);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Expected phase entries of one cycle up to SPIN entry.
    task automatic push_cycle(input int f, input int dbl, input int idle_dur);
        int l;
        l = BASE << f;
        exp_q.push_back('{1, idle_dur, 0, f, 0});
        exp_q.push_back('{2, FS * l, 0, f, 0});
        exp_q.push_back('{3, WS * l, 0, f, 0});
        if (dbl != 0) begin
            exp_q.push_back('{2, RS * l, 0, f, 0});
            exp_q.push_back('{3, WS * l, 0, f, 0});
        end
        exp_q.push_back('{4, RS * l, 0, f, 0});
    endtask

    task automatic noise();
        coin_in     = 1'($urandom_range(0, 1));
        clk_freq    = 2'($urandom_range(0, 3));
        double_wash = 1'($urandom_range(0, 1));
        timer_pause = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_phase(input int p, input bit with_noise);
        int n;
        n = 0;
        while (int'(phase) != p) begin
            if (with_noise) noise();
            @(posedge clk); #1;
            n++;
            if (n > TMO) begin
                tests++;
                fails++;
                $display("FAIL timeout: phase %0d expected %0d", phase, p);
                finish_run();
            end
        end
    endtask

    // One complete program; optionally holds the coin so the next one starts on IDLE entry.
    task automatic run_one(input int f, input int dbl, input int p_len, input bit hold,
                           input int nf, input int ndbl);
        int k;
        int pae;
        if (!started) begin
            k = $urandom_range(0, 2);
            coin_in = 1'b0;
            repeat (k) begin @(posedge clk); #1; end
            clk_freq    = 2'(f);
            double_wash = 1'(dbl);
            coin_in     = 1'b1;
            push_cycle(f, dbl, after_reset ? -1 : k + 1);
            after_reset = 1'b0;
            @(posedge clk); #1;
        end
        started = 1'b0;
        wait_phase(4, 1'b1);
        pae         = int'(timer_pause);
        timer_pause = 1'b0;
        coin_in     = hold;
        exp_q.push_back('{0, SPIN_TICKS + 1 + pae + p_len, pae + p_len, f, 1});
        if (hold) begin
            clk_freq    = 2'(nf);
            double_wash = 1'(ndbl);
            push_cycle(nf, ndbl, 1);
        end
        @(posedge clk); #1;
        repeat (p_len) begin
            timer_pause = 1'b1;
            @(posedge clk); #1;
        end
        timer_pause = 1'b0;
        wait_phase(0, 1'b0);
        if (hold) begin
            @(posedge clk); #1;
            coin_in = 1'b0;
            started = 1'b1;
        end
    endtask

    // Scoreboard monitor: on every phase change compare against the next expected entry.
    always @(negedge clk) begin
        if (mon_resync) begin
            m_prev     = 0;
            m_dur      = 0;
            m_stops    = 0;
            mon_resync = 1'b0;
        end else if (rst_n) begin
            if (int'(phase) != m_prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_phase: got %0d expected no change from %0d", phase, m_prev);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("phase", int'(phase), mon_e.ph);
                    if (mon_e.prev_dur >= 0)
                        check("prev_phase_len", m_dur, mon_e.prev_dur);
                    check("stop_cycles", m_stops, mon_e.prev_stops);
                    check("cfg_clk_freq", int'(cfg_clk_freq), mon_e.cfg);
                    check("wash_done", int'(wash_done), mon_e.wd);
                    check("soft_rst", int'(soft_rst), int'(mon_e.ph != 0));
                    check("start_spining", int'(start_spining), int'(mon_e.ph == 4));
`ifdef DOOR_LOCK_EN
                    check("door_lock", int'(door_lock), int'(mon_e.ph != 0));
`endif
                end
                m_prev  = int'(phase);
                m_dur   = 1;
                m_stops = int'(spining_counter_stop);
            end else begin
                m_dur   = m_dur + 1;
                m_stops = m_stops + int'(spining_counter_stop);
            end
        end
    end

    initial begin
        int f, dbl, p_len, nf, ndbl;
        bit hold;
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_phase", int'(phase), 0);
        check("rst_wash_done", int'(wash_done), 0);
        check("rst_cfg", int'(cfg_clk_freq), 0);
        check("rst_soft_rst", int'(soft_rst), 0);
        check("rst_start", int'(start_spining), 0);
        check("rst_stop", int'(spining_counter_stop), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        f = 0;
        dbl = 0;
        for (int t = 0; t < 10; t++) begin
            p_len = (t == 0) ? 5 : $urandom_range(0, 5);
            hold  = (t == 1) || ((t < 9) && ($urandom_range(0, 1) == 1));
            nf    = $urandom_range(0, 3);
            ndbl  = $urandom_range(0, 1);
            run_one(f, dbl, p_len, hold, nf, ndbl);
            f   = (t == 0) ? 1 : nf;
            dbl = (t == 0) ? 1 : ndbl;
        end

`ifdef DOOR_LOCK_EN
        door_closed = 1'b0;
        coin_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("door_open_coin_ignored", int'(phase), 0);
        coin_in = 1'b0;
        door_closed = 1'b1;
        @(posedge clk); #1;
`endif

        clk_freq    = 2'd2;
        double_wash = 1'b1;
        coin_in     = 1'b1;
        push_cycle(2, 1, -1);
        @(posedge clk); #1;
        wait_phase(2, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mon_resync = 1'b1;
        #1;
        check("midrst_phase", int'(phase), 0);
        check("midrst_wash_done", int'(wash_done), 0);
        check("midrst_cfg", int'(cfg_clk_freq), 0);
        check("midrst_soft_rst", int'(soft_rst), 0);
        check("midrst_start", int'(start_spining), 0);
        check("midrst_stop", int'(spining_counter_stop), 0);
        coin_in     = 1'b0;
        timer_pause = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n       = 1'b1;
        after_reset = 1'b1;
        started     = 1'b0;
        @(posedge clk); #1;
        run_one(0, 0, 0, 1'b0, 0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        finish_run();
    end

endmodule
